// File: rtl/sp_lane_rx.sv
// sp_lane_rx: single-lane serial receiver. Slides a comma detector over the
// incoming bit stream, locks byte alignment after SYNC_COUNT consecutive
// aligned commas, then delivers each non-comma byte on data_out.
// Optional feature macro: SP_LANE_RX_BYTECNT_EN adds the rx_byte_count output,
// a saturating count of data bytes received while synchronised.
module sp_lane_rx #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic        clk_8f,
  input  logic        reset_L,
  input  logic        rx_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        byte_strobe,
  output logic        rx_active
`ifdef SP_LANE_RX_BYTECNT_EN
  ,
  output logic [15:0] rx_byte_count
`endif
);

  typedef enum logic [1:0] {SEARCH, COUNT, SYNC} state_t;

  localparam logic [3:0] SYNC_N = 4'(SYNC_COUNT);

  state_t     state_q, state_nxt;
  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q, bit_cnt_nxt;
  logic [3:0] comma_cnt_q, comma_cnt_nxt;
  logic [7:0] cur_byte;
  logic       is_comma;
  logic       boundary;
  logic       sync_bnd;

  // The byte completed at this edge includes the bit currently on rx_in.
  assign cur_byte = {sr_q[6:0], rx_in};
  assign is_comma = (cur_byte == COMMA);
  assign boundary = (bit_cnt_q == 3'd7);

  // Next-state logic: sliding search, aligned comma counting, locked sync.
  always_comb begin
    state_nxt     = state_q;
    bit_cnt_nxt   = bit_cnt_q + 3'd1;
    comma_cnt_nxt = comma_cnt_q;
    sync_bnd      = 1'b0;
    case (state_q)
      SEARCH: begin
        bit_cnt_nxt = 3'd0;
        if (is_comma) begin
          comma_cnt_nxt = 4'd1;
          state_nxt     = (SYNC_COUNT == 1) ? SYNC : COUNT;
        end
      end
      COUNT: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_nxt = comma_cnt_q + 4'd1;
            if (comma_cnt_q + 4'd1 == SYNC_N)
              state_nxt = SYNC;
          end else begin
            comma_cnt_nxt = 4'd0;
            bit_cnt_nxt   = 3'd0;
            state_nxt     = SEARCH;
          end
        end
      end
      SYNC: begin
        // Only reset leaves SYNC; every eighth edge is a delivered byte slot.
        sync_bnd = boundary;
      end
      default: begin
        state_nxt     = SEARCH;
        bit_cnt_nxt   = 3'd0;
        comma_cnt_nxt = 4'd0;
      end
    endcase
  end

  // State, shift register and alignment counters.
  always_ff @(posedge clk_8f) begin
    if (!reset_L) begin
      state_q     <= SEARCH;
      sr_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_nxt;
      sr_q        <= cur_byte;
      bit_cnt_q   <= bit_cnt_nxt;
      comma_cnt_q <= comma_cnt_nxt;
    end
  end

  // Output registers: data/valid change only at SYNC byte boundaries.
  always_ff @(posedge clk_8f) begin
    if (!reset_L) begin
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      rx_active   <= 1'b0;
    end else begin
      byte_strobe <= sync_bnd;
      rx_active   <= (state_nxt == SYNC);
      if (sync_bnd) begin
        if (is_comma) begin
          valid_out <= 1'b0;
        end else begin
          data_out  <= cur_byte;
          valid_out <= 1'b1;
        end
      end
    end
  end

`ifdef SP_LANE_RX_BYTECNT_EN
  // Saturating count of data bytes delivered while synchronised.
  always_ff @(posedge clk_8f) begin
    if (!reset_L)
      rx_byte_count <= 16'h0000;
    else if (sync_bnd && !is_comma && rx_byte_count != 16'hFFFF)
      rx_byte_count <= rx_byte_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sp_lane_rx.sv
// Directed testbench for sp_lane_rx: reset, sync acquisition, data delivery,
// broken preamble, reset during SYNC and (with SP_LANE_RX_BYTECNT_EN) the
// byte counter.
module tb_sp_lane_rx;

  logic        clk_8f = 1'b0;
  logic        reset_L = 1'b0;
  logic        rx_in = 1'b0;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        byte_strobe;
  logic        rx_active;
`ifdef SP_LANE_RX_BYTECNT_EN
  logic [15:0] rx_byte_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sp_lane_rx #(.COMMA(8'hBC), .SYNC_COUNT(4)) dut (
    .clk_8f      (clk_8f),
    .reset_L     (reset_L),
    .rx_in       (rx_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .rx_active   (rx_active)
`ifdef SP_LANE_RX_BYTECNT_EN
    ,
    .rx_byte_count (rx_byte_count)
`endif
  );

  always #5 clk_8f = ~clk_8f;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bit between edges, return just after the edge that consumed it.
  task automatic bit_tx(input logic b);
    @(negedge clk_8f);
    rx_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_tx(b[i]);
  endtask

  // Send a byte checking that the outputs hold during its first seven bits.
  task automatic send_byte_hold(input string tag, input logic [7:0] b,
                                input logic [7:0] hold_data, input logic hold_valid);
    for (int i = 7; i >= 1; i--) begin
      bit_tx(b[i]);
      check_eq({tag, "_hold_data"}, {8'h00, data_out}, {8'h00, hold_data});
      check_eq({tag, "_hold_valid"}, {15'h0, valid_out}, {15'h0, hold_valid});
      check_eq({tag, "_hold_strobe"}, {15'h0, byte_strobe}, 16'h0);
    end
    bit_tx(b[0]);
  endtask

  task automatic do_reset(input int cycles);
    reset_L = 1'b0;
    for (int i = 0; i < cycles; i++) bit_tx(1'($urandom_range(1, 0)));
    reset_L = 1'b1;
  endtask

  task automatic acquire(input string tag);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    for (int i = 7; i >= 1; i--) bit_tx(1'(8'hBC >> i));
    check_eq({tag, "_pre_active"}, {15'h0, rx_active}, 16'h0);
    bit_tx(1'b0);
    check_eq({tag, "_active"}, {15'h0, rx_active}, 16'h1);
    check_eq({tag, "_valid"}, {15'h0, valid_out}, 16'h0);
    check_eq({tag, "_no_strobe"}, {15'h0, byte_strobe}, 16'h0);
  endtask

  initial begin
    // Reset with random line activity.
    do_reset(4);
    check_eq("rst_data", {8'h00, data_out}, 16'h0000);
    check_eq("rst_valid", {15'h0, valid_out}, 16'h0);
    check_eq("rst_strobe", {15'h0, byte_strobe}, 16'h0);
    check_eq("rst_active", {15'h0, rx_active}, 16'h0);

    // Sync acquire after three random bits.
    for (int i = 0; i < 3; i++) bit_tx(1'($urandom_range(1, 0)));
    acquire("acq");

    // Data 5A, comma, F0.
    send_byte_hold("d5a", 8'h5A, 8'h00, 1'b0);
    check_eq("d5a_data", {8'h00, data_out}, 16'h005A);
    check_eq("d5a_valid", {15'h0, valid_out}, 16'h1);
    check_eq("d5a_strobe", {15'h0, byte_strobe}, 16'h1);
    send_byte_hold("cbc", 8'hBC, 8'h5A, 1'b1);
    check_eq("cbc_data", {8'h00, data_out}, 16'h005A);
    check_eq("cbc_valid", {15'h0, valid_out}, 16'h0);
    check_eq("cbc_strobe", {15'h0, byte_strobe}, 16'h1);
    send_byte_hold("df0", 8'hF0, 8'h5A, 1'b0);
    check_eq("df0_data", {8'h00, data_out}, 16'h00F0);
    check_eq("df0_valid", {15'h0, valid_out}, 16'h1);
    check_eq("df0_strobe", {15'h0, byte_strobe}, 16'h1);
    bit_tx(1'b0);
    check_eq("df0_strobe_end", {15'h0, byte_strobe}, 16'h0);
    check_eq("df0_still_active", {15'h0, rx_active}, 16'h1);

    // Broken preamble: BC BC 00 then four commas.
    do_reset(1);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h00);
    check_eq("brk_inactive", {15'h0, rx_active}, 16'h0);
    acquire("brk");

    // Reset for one cycle in the middle of a data byte.
    for (int i = 7; i >= 5; i--) bit_tx(1'(8'h77 >> i));
    reset_L = 1'b0;
    bit_tx(1'b0);
    reset_L = 1'b1;
    check_eq("mid_rst_data", {8'h00, data_out}, 16'h0000);
    check_eq("mid_rst_valid", {15'h0, valid_out}, 16'h0);
    check_eq("mid_rst_active", {15'h0, rx_active}, 16'h0);
    acquire("racq");
    send_byte(8'h3C);
    check_eq("d3c_data", {8'h00, data_out}, 16'h003C);
    check_eq("d3c_valid", {15'h0, valid_out}, 16'h1);

`ifdef SP_LANE_RX_BYTECNT_EN
    do_reset(2);
    check_eq("cnt_rst", rx_byte_count, 16'd0);
    acquire("cacq");
    for (int k = 0; k < 10; k++) begin
      send_byte(8'(8'h10 + k));
      send_byte(8'hBC);
    end
    check_eq("cnt_ten", rx_byte_count, 16'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_lane_rx.md
SP_LANE_RX -- requirements
Module: sp_lane_rx

Interface
REQ-001 Parameter COMMA, default 8'hBC: idle/alignment byte transmitted on a lane when its stripe is not valid.
REQ-002 Parameter SYNC_COUNT, default 4: number of consecutive aligned COMMA bytes needed to declare the lane active; legal range 1..15.
REQ-003 clk_8f  input  1  bit-rate clock; the only clock in the block; all flops update on its rising edge.
REQ-004 reset_L  input  1  reset, synchronous and active-low.
REQ-005 rx_in  input  1  serial lane input, MSB first, one bit per clk_8f cycle.
REQ-006 data_out  output  8  last received non-COMMA byte.
REQ-007 valid_out  output  1  data_out holds a byte received in the current byte slot.
REQ-008 byte_strobe  output  1  one-cycle pulse at each byte boundary while active.
REQ-009 rx_active  output  1  lane is aligned and synchronised.

Function
REQ-010 The block SHALL shift rx_in every cycle as sr <= {sr[6:0], rx_in}; "current byte" means {sr[6:0], rx_in} at that edge.
REQ-011 The block SHALL implement states SEARCH, COUNT, SYNC, with SEARCH entered from reset.
REQ-012 SEARCH: the current byte SHALL be compared with COMMA every cycle, bit-by-bit sliding; on match go to COUNT, set bit_cnt=0 and comma_cnt=1.
REQ-013 Aligned states: bit_cnt SHALL increment mod 8 every cycle; a byte boundary SHALL occur when bit_cnt==7, i.e. every 8th cycle after the aligning comma.
REQ-014 If SYNC_COUNT==1, a SEARCH match SHALL go directly to SYNC.
REQ-015 COUNT, at a boundary: current byte == COMMA -> comma_cnt+1, entering SYNC when it reaches SYNC_COUNT; otherwise -> SEARCH, comma_cnt=0.
REQ-016 rx_active SHALL be 1 exactly while in SYNC, asserted the cycle after the SYNC-entering edge.
REQ-017 SYNC, at each boundary: current byte != COMMA -> data_out <= byte, valid_out <= 1; current byte == COMMA -> valid_out <= 0, data_out holds.
REQ-018 valid_out and data_out SHALL be stable between boundaries (held 8 cycles).
REQ-019 byte_strobe SHALL pulse high for one cycle, the cycle after each SYNC boundary edge, whatever the byte value; it SHALL not pulse on the SYNC-entering edge.
REQ-020 Latency: last bit of a byte on rx_in at edge t -> data_out/valid_out valid at edge t+1.
REQ-021 SYNC SHALL be left only by reset; non-COMMA bytes never cause loss of sync.
REQ-022 In SEARCH and COUNT, valid_out, byte_strobe and rx_active SHALL be 0 and data_out SHALL hold.

Reset
REQ-023 With reset_L==0 at a clk_8f edge: state=SEARCH, sr=0, bit_cnt=0, comma_cnt=0, data_out=8'h00, valid_out=0, byte_strobe=0, rx_active=0.
REQ-024 Reset mid-byte or mid-SYNC SHALL discard partial bytes; realignment SHALL need a fresh SYNC_COUNT commas after release.

Configuration
REQ-025 Macro SP_LANE_RX_BYTECNT_EN defined: SHALL add output rx_byte_count [15:0], incremented on each SYNC boundary with valid_out being set, saturating at 16'hFFFF, cleared by reset.
REQ-026 Macro undefined: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset: hold reset_L=0 for 4 cycles with random rx_in -> all outputs 0, rx_active=0.
REQ-028 Sync acquire: 3 random bits, then 4x 8'hBC -> rx_active=1 the edge after the 4th comma's last bit; valid_out=0.
REQ-029 Data: after sync, send 8'h5A, 8'hBC, 8'hF0 -> data_out=8'h5A valid_out=1 for 8 cycles, then valid_out=0 data_out=8'h5A, then data_out=8'hF0 valid_out=1; byte_strobe pulses every 8 cycles.
REQ-030 Broken preamble: 8'hBC, 8'hBC, 8'h00, then 4x 8'hBC -> rx_active only after the final 4th comma.
REQ-031 Reset mid-SYNC: reset_L=0 for 1 cycle during a data byte -> outputs cleared; after release 4x 8'hBC then 8'h3C -> data_out=8'h3C valid_out=1.
REQ-032 With SP_LANE_RX_BYTECNT_EN: 10 data bytes interleaved with commas -> rx_byte_count=10; without the macro the bench compiles with the port absent.
